// File: rtl/gun_aim_pkg.sv
// Shared types, constants and the position clamp used by the gun aim controller.
package gun_aim_pkg;

    typedef enum logic [1:0] {
        SRC_DIGITAL = 2'd0,
        SRC_MOUSE   = 2'd1,
        SRC_ANALOG  = 2'd2
    } src_t;

    typedef enum logic [1:0] {
        AX_IDLE = 2'd0,
        AX_SLOW = 2'd1,
        AX_FAST = 2'd2
    } axis_st_t;

    localparam logic [5:0] GUN_CENTER = 6'd32;
    localparam logic [5:0] GUN_MAX    = 6'd63;

    function automatic logic [5:0] clamp_gun(input logic signed [12:0] v);
        if (v < 13'sd0)
            return 6'd0;
        if (v > 13'sd63)
            return GUN_MAX;
        return v[5:0];
    endfunction

endpackage

// File: rtl/gun_axis_digital.sv
// One axis of digital aim: press moves immediately, slow repeat while held, then full-rate after a hold time.
module gun_axis_digital
    import gun_aim_pkg::*;
#(
    parameter int STEP_DIV   = 2,
    parameter int ACCEL_HOLD = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              tick_en,
    input  logic              dec,
    input  logic              inc,
    input  logic              center,
    output logic signed [1:0] move
);

    localparam logic [7:0] DIV_LAST  = 8'(STEP_DIV - 1);
    localparam logic [7:0] HOLD_LAST = 8'(ACCEL_HOLD);

    axis_st_t   st, st_n;
    logic [7:0] div, div_n;
    logic [7:0] hold, hold_n;
    logic       dir_r, dir_n;
    logic       pressed;
    logic signed [1:0] step;

    // Both buttons together cancel out and count as released.
    assign pressed = inc ^ dec;
    assign step    = inc ? 2'sb01 : 2'sb11;

    always_comb begin
        st_n   = st;
        div_n  = div;
        hold_n = hold;
        dir_n  = dir_r;
        move   = 2'sb00;
        if (center) begin
            st_n   = AX_IDLE;
            div_n  = 8'd0;
            hold_n = 8'd0;
        end else if (tick_en) begin
            if (!pressed) begin
                st_n   = AX_IDLE;
                div_n  = 8'd0;
                hold_n = 8'd0;
            end else if (st == AX_IDLE || inc != dir_r) begin
                // fresh press or reversal restarts the slow phase
                move   = step;
                st_n   = AX_SLOW;
                div_n  = 8'd0;
                hold_n = 8'd0;
                dir_n  = inc;
            end else if (st == AX_SLOW) begin
                hold_n = hold + 8'd1;
                if (div == DIV_LAST) begin
                    move  = step;
                    div_n = 8'd0;
                end else begin
                    div_n = div + 8'd1;
                end
                if (hold + 8'd1 == HOLD_LAST)
                    st_n = AX_FAST;
            end else begin
                move = step;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            st    <= AX_IDLE;
            div   <= 8'd0;
            hold  <= 8'd0;
            dir_r <= 1'b0;
        end else begin
            st    <= st_n;
            div   <= div_n;
            hold  <= hold_n;
            dir_r <= dir_n;
        end
    end

endmodule

// File: rtl/gun_aim_ctrl.sv
// Light-gun aim controller: arbitrates joystick, mouse and analog stick and
// updates the 6-bit gun position on each rising edge of the 4 ms tick.
module gun_aim_ctrl
    import gun_aim_pkg::*;
#(
    parameter int STEP_DIV    = 2,
    parameter int ACCEL_HOLD  = 16,
    parameter int ANA_DEAD    = 16,
    parameter int MOUSE_SHIFT = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       tick_4ms,
    input  logic       joy_left,
    input  logic       joy_right,
    input  logic       joy_up,
    input  logic       joy_down,
    input  logic       center,
    input  logic       ana_valid,
    input  logic [7:0] ana_x,
    input  logic [7:0] ana_y,
    input  logic       mouse_valid,
    input  logic [8:0] mouse_dx,
    input  logic [8:0] mouse_dy,
    output logic [5:0] gun_h,
    output logic [5:0] gun_v,
    output logic [1:0] src
);

    localparam logic signed [8:0] DEAD = 9'(ANA_DEAD);

    logic              tick_r, tick, tick_en;
    src_t              src_q, src_n;
    logic              mouse_hit, ana_hit;
    logic signed [8:0] ax, ay;
    logic signed [1:0] move_h, move_v;
    logic signed [11:0] acc_h, acc_v, step_h, step_v;
    logic              mouse_take;

    assign tick = tick_4ms & ~tick_r;
    assign src  = src_q;

    assign ax        = {ana_x[7], ana_x};
    assign ay        = {ana_y[7], ana_y};
    assign ana_hit   = ana_valid & ((ax > DEAD) | (ax < -DEAD) | (ay > DEAD) | (ay < -DEAD));
    assign mouse_hit = mouse_valid & ((|mouse_dx) | (|mouse_dy));

    always_comb begin
        src_n = src_q;
        if (joy_left | joy_right | joy_up | joy_down)
            src_n = SRC_DIGITAL;
        else if (mouse_hit)
            src_n = SRC_MOUSE;
        else if (ana_hit)
            src_n = SRC_ANALOG;
    end

    assign tick_en    = tick & (src_q == SRC_DIGITAL);
    assign mouse_take = tick & (src_q == SRC_MOUSE);

    gun_axis_digital #(.STEP_DIV(STEP_DIV), .ACCEL_HOLD(ACCEL_HOLD)) u_axis_h (
        .clk_sys (clk_sys),
        .reset   (reset),
        .tick_en (tick_en),
        .dec     (joy_left),
        .inc     (joy_right),
        .center  (center),
        .move    (move_h)
    );

    gun_axis_digital #(.STEP_DIV(STEP_DIV), .ACCEL_HOLD(ACCEL_HOLD)) u_axis_v (
        .clk_sys (clk_sys),
        .reset   (reset),
        .tick_en (tick_en),
        .dec     (joy_up),
        .inc     (joy_down),
        .center  (center),
        .move    (move_v)
    );

    assign step_h = acc_h >>> MOUSE_SHIFT;
    assign step_v = acc_v >>> MOUSE_SHIFT;

    // Drain the whole-unit part on a consumed tick, add the new delta, saturate at +/-2047.
    function automatic logic signed [11:0] acc_update(input logic signed [11:0] acc,
                                                      input logic signed [8:0]  d,
                                                      input logic               take,
                                                      input logic               add);
        logic signed [13:0] s, whole;
        s     = 14'(acc);
        whole = 14'(acc >>> MOUSE_SHIFT);
        if (take)
            s = s - (whole <<< MOUSE_SHIFT);
        if (add)
            s = s + 14'(d);
        if (s > 14'sd2047)
            return 12'sd2047;
        if (s < -14'sd2047)
            return -12'sd2047;
        return s[11:0];
    endfunction

    // Sum is kept wide enough that no step can wrap before clamping.
    function automatic logic [5:0] add_clamp(input logic [5:0] g, input logic signed [11:0] d);
        logic signed [12:0] s;
        s = $signed({7'd0, g}) + 13'(d);
        return clamp_gun(s);
    endfunction

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tick_r <= 1'b1;
            src_q  <= SRC_DIGITAL;
            gun_h  <= GUN_CENTER;
            gun_v  <= GUN_CENTER;
            acc_h  <= 12'sd0;
            acc_v  <= 12'sd0;
        end else begin
            tick_r <= tick_4ms;
            src_q  <= src_n;
            if (center || (src_q == SRC_MOUSE && src_n != SRC_MOUSE)) begin
                acc_h <= 12'sd0;
                acc_v <= 12'sd0;
            end else begin
                acc_h <= acc_update(acc_h, $signed(mouse_dx), mouse_take, mouse_valid);
                acc_v <= acc_update(acc_v, $signed(mouse_dy), mouse_take, mouse_valid);
            end
            if (center) begin
                gun_h <= GUN_CENTER;
                gun_v <= GUN_CENTER;
            end else if (tick) begin
                case (src_q)
                    SRC_DIGITAL: begin
                        gun_h <= add_clamp(gun_h, 12'(move_h));
                        gun_v <= add_clamp(gun_v, 12'(move_v));
                    end
                    SRC_MOUSE: begin
                        gun_h <= add_clamp(gun_h, step_h);
                        gun_v <= add_clamp(gun_v, step_v);
                    end
                    SRC_ANALOG: begin
                        gun_h <= {~ana_x[7], ana_x[6:2]};
                        gun_v <= {~ana_y[7], ana_y[6:2]};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gun_aim_ctrl.sv
// Directed bench for gun_aim_ctrl: digital accel/clamp, mouse accumulation, analog mapping, center and reset.
module tb_gun_aim_ctrl;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       tick_4ms = 1'b0;
    logic       joy_left = 1'b0, joy_right = 1'b0, joy_up = 1'b0, joy_down = 1'b0;
    logic       center = 1'b0;
    logic       ana_valid = 1'b0;
    logic [7:0] ana_x = 8'd0, ana_y = 8'd0;
    logic       mouse_valid = 1'b0;
    logic [8:0] mouse_dx = 9'd0, mouse_dy = 9'd0;
    logic [5:0] gun_h, gun_v;
    logic [1:0] src;

    int nchk = 0;
    int nerr = 0;

    always #5 clk_sys = ~clk_sys;

    gun_aim_ctrl dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .tick_4ms    (tick_4ms),
        .joy_left    (joy_left),
        .joy_right   (joy_right),
        .joy_up      (joy_up),
        .joy_down    (joy_down),
        .center      (center),
        .ana_valid   (ana_valid),
        .ana_x       (ana_x),
        .ana_y       (ana_y),
        .mouse_valid (mouse_valid),
        .mouse_dx    (mouse_dx),
        .mouse_dy    (mouse_dy),
        .gun_h       (gun_h),
        .gun_v       (gun_v),
        .src         (src)
    );

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // One rising edge on tick_4ms; returns on the negedge after the update edge.
    task automatic do_tick(input int n);
        repeat (n) begin
            @(negedge clk_sys) tick_4ms = 1'b1;
            @(negedge clk_sys) tick_4ms = 1'b0;
        end
    endtask

    task automatic strobe(input logic [8:0] dx, input logic [8:0] dy);
        @(negedge clk_sys);
        mouse_valid = 1'b1;
        mouse_dx    = dx;
        mouse_dy    = dy;
        @(negedge clk_sys);
        mouse_valid = 1'b0;
        mouse_dx    = 9'd0;
        mouse_dy    = 9'd0;
    endtask

    initial begin
        cyc(2);
        chk("rst_h", int'(gun_h), 32);
        chk("rst_v", int'(gun_v), 32);
        chk("rst_src", int'(src), 0);

        // digital hold right: slow every other tick, fast after 16 held ticks
        reset = 1'b0;
        joy_right = 1'b1;
        do_tick(1);  chk("dig_t1", int'(gun_h), 33);
        do_tick(1);  chk("dig_t2", int'(gun_h), 33);
        do_tick(14); chk("dig_t16", int'(gun_h), 40);
        do_tick(1);  chk("dig_t17", int'(gun_h), 41);
        do_tick(1);  chk("dig_t18", int'(gun_h), 42);
        do_tick(22); chk("dig_t40_clamp", int'(gun_h), 63);
        chk("dig_src", int'(src), 0);
        chk("dig_v", int'(gun_v), 32);

        joy_left = 1'b1;
        do_tick(10); chk("both_held", int'(gun_h), 63);
        joy_right = 1'b0;
        do_tick(1);  chk("left_after_both", int'(gun_h), 62);
        joy_left = 1'b0;

        @(negedge clk_sys) center = 1'b1;
        @(negedge clk_sys) center = 1'b0;
        chk("center_h", int'(gun_h), 32);

        // mouse: 3 x +5 -> acc 15 -> step +1, rem 7; then -9 -> -2 -> step -1
        strobe(9'd5, 9'd0);
        strobe(9'd5, 9'd0);
        strobe(9'd5, 9'd0);
        chk("mouse_src", int'(src), 1);
        do_tick(1);  chk("mouse_h1", int'(gun_h), 33);
        strobe(9'h1F7, 9'd0);
        do_tick(1);  chk("mouse_h2", int'(gun_h), 32);
        strobe(9'd0, 9'h1EC);
        do_tick(1);
        chk("mouse_v3", int'(gun_v), 29);
        chk("mouse_h3", int'(gun_h), 32);

        // analog deadzone boundary, then absolute mapping
        ana_valid = 1'b1;
        ana_x = 8'd10; ana_y = 8'hF6;
        cyc(2); chk("ana_small", int'(src), 1);
        ana_x = 8'd16; ana_y = 8'hF0;
        cyc(2); chk("ana_edge", int'(src), 1);
        ana_x = 8'hEF; ana_y = 8'd0;
        cyc(2); chk("ana_over", int'(src), 2);
        ana_x = 8'h80; ana_y = 8'h7F;
        do_tick(1);
        chk("ana_h", int'(gun_h), 0);
        chk("ana_v", int'(gun_v), 63);
        ana_valid = 1'b0;

        @(negedge clk_sys) center = 1'b1;
        @(negedge clk_sys) center = 1'b0;
        chk("center2_h", int'(gun_h), 32);
        chk("center2_v", int'(gun_v), 32);
        chk("center_keeps_src", int'(src), 2);

        // into FAST, then center coincident with a tick
        joy_right = 1'b1;
        do_tick(20); chk("fast_h", int'(gun_h), 44);
        chk("fast_src", int'(src), 0);
        @(negedge clk_sys); center = 1'b1; tick_4ms = 1'b1;
        @(negedge clk_sys); center = 1'b0; tick_4ms = 1'b0;
        chk("ctr_tick_h", int'(gun_h), 32);
        chk("ctr_tick_v", int'(gun_v), 32);
        do_tick(1); chk("post_ctr_t1", int'(gun_h), 33);
        do_tick(1); chk("post_ctr_t2", int'(gun_h), 33);

        // reset with tick held high, no false edge after release
        @(negedge clk_sys); tick_4ms = 1'b1; reset = 1'b1;
        @(negedge clk_sys);
        chk("midrst_h", int'(gun_h), 32);
        chk("midrst_v", int'(gun_v), 32);
        chk("midrst_src", int'(src), 0);
        reset = 1'b0;
        cyc(3); chk("no_false_edge", int'(gun_h), 32);
        tick_4ms = 1'b0;
        cyc(1);
        tick_4ms = 1'b1;
        cyc(1); chk("edge_after_rst", int'(gun_h), 33);
        tick_4ms = 1'b0;
        joy_right = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
